// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed 7-segment scanner for the reaction-time
// counter. Scans one digit per slot with leading dead time, blanks leading
// zeros, shows "E" for invalid BCD and flashes dashes on timeout.
// Optional feature macro: SEG7_DP_EN (decimal point after digit 0, x.xxx).
module seg7_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEAD_CYC       = 4,
  parameter int unsigned BLINK_TICKS    = 256,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        timeout,
  input  logic        disp_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  dig
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_ERR  = 7'h79;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  slot_e         slot_q, slot_d;
  logic [15:0]   shbcd_q, shbcd_d;
  logic          shto_q, shto_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bon_q, bon_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    dig_q, dig_d;

  logic [3:0]    nib [4];
  logic [3:0]    zero;
  logic [3:0]    blank;
  logic [3:0]    cur_nib;
  logic [3:0]    onehot;
  logic          visible;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_ERR;
    endcase
    return s;
  endfunction

  assign tick = (presc_q == PW'(SCAN_DIV - 1));

  // Prescaler wrap and slot advance on tick
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    slot_d  = slot_q;
    if (tick) begin
      case (slot_q)
        SLOT0:   slot_d = SLOT1;
        SLOT1:   slot_d = SLOT2;
        SLOT2:   slot_d = SLOT3;
        default: slot_d = SLOT0;
      endcase
    end
  end

  // Frame capture into shadow registers on the 3->0 wrap tick
  always_comb begin
    shbcd_d = shbcd_q;
    shto_d  = shto_q;
    if (tick && (slot_q == SLOT3)) begin
      shbcd_d = bcd_in;
      shto_d  = timeout;
    end
  end

  // Blink counter: runs on slot ticks only while the captured timeout is set,
  // so the capturing tick itself does not count and the first frame starts ON
  always_comb begin
    bcnt_d = bcnt_q;
    bon_d  = bon_q;
    if (!shto_q) begin
      bcnt_d = '0;
      bon_d  = 1'b1;
    end else if (tick) begin
      if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
        bcnt_d = '0;
        bon_d  = ~bon_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Blanking masks from the next-frame shadow value
  always_comb begin
    nib[0] = shbcd_d[15:12];
    nib[1] = shbcd_d[11:8];
    nib[2] = shbcd_d[7:4];
    nib[3] = shbcd_d[3:0];
    for (int unsigned i = 0; i < 4; i++) begin
      zero[i] = (nib[i] == 4'd0);
    end
`ifdef SEG7_DP_EN
    blank[0] = 1'b0;
    blank[1] = zero[1];
    blank[2] = zero[1] & zero[2];
    blank[3] = 1'b0;
`else
    blank[0] = zero[0];
    blank[1] = zero[0] & zero[1];
    blank[2] = zero[0] & zero[1] & zero[2];
    blank[3] = 1'b0;
`endif
  end

  // Decode from next-state values so the registered outputs line up with the
  // prescaler: dead cycles show dig=0 with the new slot's pattern on seg
  always_comb begin
    cur_nib = nib[slot_d];
    onehot  = 4'b0001 << slot_d;
    visible = (presc_d >= PW'(DEAD_CYC));
    seg_d   = '0;
    dp_d    = 1'b0;
    dig_d   = '0;
    if (disp_en) begin
      if (shto_d) begin
        if (bon_d) begin
          seg_d = SEG_DASH;
          dig_d = visible ? onehot : '0;
        end
      end else if (!blank[slot_d]) begin
        seg_d = bcd_to_seg(cur_nib);
        dig_d = visible ? onehot : '0;
`ifdef SEG7_DP_EN
        dp_d  = visible && (slot_d == SLOT0);
`endif
      end
    end
  end

  // Scan state, shadow, blink and registered logical outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      slot_q  <= SLOT0;
      shbcd_q <= '0;
      shto_q  <= 1'b0;
      bcnt_q  <= '0;
      bon_q   <= 1'b1;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      dig_q   <= '0;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      shbcd_q <= shbcd_d;
      shto_q  <= shto_d;
      bcnt_q  <= bcnt_d;
      bon_q   <= bon_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
    end
  end

  assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp  = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
  assign dig = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan: directed steps plus randomized stimulus, checked
// against a frame/slot arithmetic model of the display.
module tb_seg7_scan;

  localparam int unsigned SD = 4;
  localparam int unsigned DC = 1;
  localparam int unsigned BT = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        timeout;
  logic        disp_en;
  logic [6:0]  seg, seg_al;
  logic        dp, dp_al;
  logic [3:0]  dig, dig_al;

  int tests;
  int fails;

  // Model state: cycles since reset release, captured frame, timeout start slot
  int unsigned n;
  int unsigned to_start;
  logic [15:0] sh_bcd;
  logic        sh_to;
  logic        en_s;

  seg7_scan #(
    .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_TICKS(BT),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .timeout(timeout),
    .disp_en(disp_en), .seg(seg), .dp(dp), .dig(dig)
  );

  seg7_scan #(
    .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_TICKS(BT),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .timeout(timeout),
    .disp_en(disp_en), .seg(seg_al), .dp(dp_al), .dig(dig_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] lut(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (v > 4'd9) return 7'h79;
    return tbl[v];
  endfunction

  function automatic void model(output logic [6:0] es, output logic edp,
                                output logic [3:0] ed);
    int unsigned p, s, sl, k, first;
    logic [3:0] d [4];
    bit vis, blank;
    p   = n % SD;
    s   = n / SD;
    sl  = s % 4;
    vis = (p >= DC);
    es  = '0;
    edp = 1'b0;
    ed  = '0;
    if (!en_s) return;
    if (sh_to) begin
      k = s - to_start;
      if (((k / BT) % 2) == 0) begin
        es = 7'h40;
        ed = vis ? 4'(1 << sl) : 4'h0;
      end
      return;
    end
    for (int i = 0; i < 4; i++) d[i] = 4'((sh_bcd >> (12 - 4 * i)) & 16'hF);
`ifdef SEG7_DP_EN
    first = 1;
    blank = (sl == 1) || (sl == 2);
`else
    first = 0;
    blank = (sl < 3);
`endif
    for (int unsigned i = first; i <= sl; i++) if (d[i] != 4'd0) blank = 1'b0;
    if (!blank) begin
      es = lut(d[sl]);
      ed = vis ? 4'(1 << sl) : 4'h0;
`ifdef SEG7_DP_EN
      edp = vis && (sl == 0);
`endif
    end
  endfunction

  task automatic check_all();
    logic [6:0] es;
    logic       edp;
    logic [3:0] ed;
    model(es, edp, ed);
    tests++;
    assert (seg === es) else begin
      fails++;
      $error("FAIL seg n=%0d got %h exp %h", n, seg, es);
    end
    tests++;
    assert (dig === ed) else begin
      fails++;
      $error("FAIL dig n=%0d got %h exp %h", n, dig, ed);
    end
    tests++;
    assert (dp === edp) else begin
      fails++;
      $error("FAIL dp n=%0d got %b exp %b", n, dp, edp);
    end
    tests++;
    assert ({seg_al, dp_al, dig_al} === ~{es, edp, ed}) else begin
      fails++;
      $error("FAIL active_low n=%0d got %h/%b/%h exp %h/%b/%h",
             n, seg_al, dp_al, dig_al, ~es, ~edp, ~ed);
    end
  endtask

  task automatic check_reset(input string tag);
    tests++;
    assert ({seg, dp, dig} === 12'h000) else begin
      fails++;
      $error("FAIL %s got %h/%b/%h exp 00/0/0", tag, seg, dp, dig);
    end
    tests++;
    assert ({seg_al, dp_al, dig_al} === 12'hFFF) else begin
      fails++;
      $error("FAIL %s_al got %h/%b/%h exp 7f/1/f", tag, seg_al, dp_al, dig_al);
    end
  endtask

  // One clock: update the model for the edge using current inputs, then check
  task automatic step();
    int unsigned nx;
    nx = n + 1;
    if ((nx % (4 * SD)) == 0) begin
      if (timeout && !sh_to) to_start = nx / SD;
      sh_bcd = bcd_in;
      sh_to  = timeout;
    end
    en_s = disp_en;
    @(posedge clk);
    #1;
    n = nx;
    check_all();
  endtask

  task automatic run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) step();
  endtask

  task automatic model_reset();
    n        = 0;
    to_start = 0;
    sh_bcd   = '0;
    sh_to    = 1'b0;
    en_s     = 1'b1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    bcd_in  = 16'h1234;
    timeout = 1'b0;
    disp_en = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Shadow is 0 for frame 0, then 1234 with dead cycle per slot
    run(3 * 4 * SD);

    // Reset mid-slot: immediate, then frame 0 shows only digit 3 = 0
    while ((n % SD) != 2) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(2 * 4 * SD);

    // Leading-zero blanking and invalid nibble
    bcd_in = 16'h0045;
    run(2 * 4 * SD);
    bcd_in = 16'h00A5;
    run(2 * 4 * SD);
    bcd_in = 16'h0000;
    run(2 * 4 * SD);
    bcd_in = 16'h0103;
    run(2 * 4 * SD);

    // Mid-frame change does not tear
    bcd_in = 16'h1234;
    run(2 * 4 * SD);
    while (((n / SD) % 4) != 1) step();
    bcd_in = 16'h5678;
    run(2 * 4 * SD);

    // Timeout flashing, disp_en darkening, then recovery
    timeout = 1'b1;
    run(3 * 4 * SD);
    disp_en = 1'b0;
    run(5);
    disp_en = 1'b1;
    run(2 * 4 * SD);
    timeout = 1'b0;
    run(2 * 4 * SD);
    disp_en = 1'b0;
    run(6);
    disp_en = 1'b1;
    run(4 * SD);

    // Randomized input traffic
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 23) == 0) begin
        for (int j = 0; j < 4; j++) begin
          logic [3:0] v;
          v = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          bcd_in[15 - 4 * j -: 4] = v;
        end
      end
      if ($urandom_range(0, 59) == 0) timeout = ~timeout;
      disp_en = ($urandom_range(0, 19) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
